commit_wb_arbiter: RTL and testbench

Merges the per-unit commit streams (ALU, LSU, CSR, FPU, GPU) into the single commit/writeback stream that feeds the register-file writeback and retire logic. It sits directly downstream of the FPU unit's commit port and its sibling execute units. Arbitration is round-robin with an end-of-packet lock for multi-beat responses. The merged result leaves through one registered output stage with valid/ready backpressure.

---
 rtl/commit_wb_arbiter_pkg.sv | 42 ++++
 rtl/commit_wb_arbiter_if.sv | 37 +++
 rtl/commit_rr_arbiter.sv | 101 ++++++++++
 rtl/commit_wb_arbiter.sv | 81 ++++++++
 tb/tb_commit_wb_arbiter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_wb_arbiter_pkg.sv
// commit_wb_arbiter_pkg
//   Shared definitions for the commit/writeback merge block: source index
//   constants, the packed commit record layout, the lock FSM state type and
//   a helper that sizes source-index fields.
package commit_wb_arbiter_pkg;

    localparam int NW_BITS     = 2;
    localparam int NUM_THREADS = 4;
    localparam int NR_BITS     = 5;

    localparam int COMMIT_DATAW = NW_BITS + NUM_THREADS + 32 + NR_BITS + 1
                                + NUM_THREADS * 32 + 1;

    localparam int COMMIT_NUM_SRCS = 5;
    localparam int COMMIT_SRC_ALU  = 0;
    localparam int COMMIT_SRC_LSU  = 1;
    localparam int COMMIT_SRC_CSR  = 2;
    localparam int COMMIT_SRC_FPU  = 3;
    localparam int COMMIT_SRC_GPU  = 4;

    // eop sits in bit 0 of the packed record.
    typedef struct packed {
        logic [NW_BITS-1:0]        wid;
        logic [NUM_THREADS-1:0]    tmask;
        logic [31:0]               pc;
        logic [NR_BITS-1:0]        rd;
        logic                      wb;
        logic [NUM_THREADS*32-1:0] data;
        logic                      eop;
    } commit_rec_t;

    typedef enum logic {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_e;

    // A single source still needs a 1-bit index field.
    function automatic int sel_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/commit_wb_arbiter_if.sv
// commit_wb_arbiter_if
//   Bundles the per-source commit request ports and the merged output port.
//   Handshake: a beat transfers on any clock edge where valid && ready are
//   both high; a producer holds valid and data stable until that edge, and
//   ready never depends on the data being offered.
//   slave  : the arbiter (consumes req_*, produces out_* and debug state)
//   master : the environment (produces req_*, consumes out_*)
interface commit_wb_arbiter_if #(
    parameter int NUM_REQS = commit_wb_arbiter_pkg::COMMIT_NUM_SRCS,
    parameter int DATAW    = commit_wb_arbiter_pkg::COMMIT_DATAW
) ();
    localparam int SEL_W = commit_wb_arbiter_pkg::sel_width(NUM_REQS);

    logic [NUM_REQS-1:0]            req_valid;
    logic [NUM_REQS-1:0][DATAW-1:0] req_data;
    logic [NUM_REQS-1:0]            req_ready;

    logic                           out_valid;
    logic [DATAW-1:0]               out_data;
    logic [SEL_W-1:0]               out_sel;
    logic                           out_ready;

    commit_wb_arbiter_pkg::lock_state_e dbg_lock_state;
    logic [SEL_W-1:0]                   dbg_lock_owner;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_sel,
        output dbg_lock_state, dbg_lock_owner
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_sel,
        input  dbg_lock_state, dbg_lock_owner
    );
endinterface

// File: rtl/commit_rr_arbiter.sv
// commit_rr_arbiter
//   Round-robin grant with an end-of-packet lock.
//   clk, reset   : clock, synchronous active-high reset
//   requests     : per-source valid
//   enable       : a grant becomes a transfer only when enable is high
//   grant_eop    : eop bit of the record offered by the granted source
//   grant        : one-hot grant
//   grant_idx    : index of the granted source
//   grant_valid  : some source is granted
//   lock_state   : current lock FSM state
//   lock_owner   : source owning the lock (meaningful while LOCKED)
module commit_rr_arbiter
    import commit_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQS = COMMIT_NUM_SRCS,
    parameter int SEL_W    = sel_width(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] requests,
    input  logic                enable,
    input  logic                grant_eop,
    output logic [NUM_REQS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx,
    output logic                grant_valid,
    output lock_state_e         lock_state,
    output logic [SEL_W-1:0]    lock_owner
);

    lock_state_e      state_q, state_d;
    logic [SEL_W-1:0] owner_q, owner_d;
    logic [SEL_W-1:0] last_grant_q;
    logic [SEL_W-1:0] cand;
    logic             transfer;

    // While locked only the owner can win; an idle owner leaves no grant at
    // all so the packet cannot be interleaved with another source.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        if (state_q == LOCK_LOCKED) begin
            if (requests[owner_q]) begin
                grant_valid = 1'b1;
                grant_idx   = owner_q;
            end
        end else begin
            for (int k = 1; k <= NUM_REQS; k++) begin
                cand = SEL_W'((int'(last_grant_q) + k) % NUM_REQS);
                if (!grant_valid && requests[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign transfer = grant_valid && enable;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            LOCK_UNLOCKED: begin
                if (transfer && !grant_eop) begin
                    state_d = LOCK_LOCKED;
                    owner_d = grant_idx;
                end
            end
            LOCK_LOCKED: begin
                if (transfer && grant_eop) begin
                    state_d = LOCK_UNLOCKED;
                end
            end
            default: state_d = LOCK_UNLOCKED;
        endcase
    end

    // last_grant resets to the highest index so source 0 has first priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOCK_UNLOCKED;
            owner_q      <= '0;
            last_grant_q <= SEL_W'(NUM_REQS - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (transfer) begin
                last_grant_q <= grant_idx;
            end
        end
    end

    assign lock_state = state_q;
    assign lock_owner = owner_q;

endmodule

// File: rtl/commit_wb_arbiter.sv
// commit_wb_arbiter
//   Merges the ALU/LSU/CSR/FPU/GPU commit streams into one registered
//   commit/writeback stream.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of commit_wb_arbiter_if
//                req_valid/req_data/req_ready  per-source commit inputs
//                out_valid/out_data/out_sel/out_ready  merged output
//                dbg_lock_state/dbg_lock_owner  lock FSM observation
module commit_wb_arbiter
    import commit_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQS = COMMIT_NUM_SRCS,
    parameter int DATAW    = COMMIT_DATAW
) (
    input logic            clk,
    input logic            reset,
    commit_wb_arbiter_if.slave bus
);

    localparam int SEL_W = sel_width(NUM_REQS);

    logic                stall;
    logic                transfer;
    logic [NUM_REQS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic                grant_valid;
    logic [DATAW-1:0]    sel_data;
    lock_state_e         lock_state;
    logic [SEL_W-1:0]    lock_owner;

    logic                out_valid_q;
    logic [DATAW-1:0]    out_data_q;
    logic [SEL_W-1:0]    out_sel_q;

    // A held output blocks every source, so nothing is accepted that the
    // output register could not take this cycle.
    assign stall    = out_valid_q && !bus.out_ready;
    assign sel_data = bus.req_data[grant_idx];
    assign transfer = grant_valid && !stall;

    commit_rr_arbiter #(
        .NUM_REQS (NUM_REQS),
        .SEL_W    (SEL_W)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .requests    (bus.req_valid),
        .enable      (!stall),
        .grant_eop   (sel_data[0]),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .lock_state  (lock_state),
        .lock_owner  (lock_owner)
    );

    assign bus.req_ready = grant & {NUM_REQS{!stall}};

    // Reloading whenever not stalled gives back-to-back records with no
    // bubble when out_ready and a new transfer coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else if (!stall) begin
            out_valid_q <= transfer;
            if (transfer) begin
                out_data_q <= sel_data;
                out_sel_q  <= grant_idx;
            end
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_data       = out_data_q;
    assign bus.out_sel        = out_sel_q;
    assign bus.dbg_lock_state = lock_state;
    assign bus.dbg_lock_owner = lock_owner;

endmodule

// File: tb/tb_commit_wb_arbiter.sv
module tb_commit_wb_arbiter;
    import commit_wb_arbiter_pkg::*;

    localparam int N = 5;
    localparam int W = COMMIT_DATAW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    commit_wb_arbiter_if #(.NUM_REQS(N), .DATAW(W)) bus ();

    commit_wb_arbiter #(.NUM_REQS(N), .DATAW(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic         gap;
        logic [W-1:0] data;
    } beat_t;

    beat_t        src_q[N][$];
    logic [N-1:0] acc = '0;
    logic [N-1:0] shown_gap = '0;
    int           ret_q[$];
    logic [W-1:0] exp_q[$];

    // Reference model state: what the merged output must hold, which source
    // was granted last, and who owns the packet lock (-1 = nobody).
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_sel;
    int           m_last;
    int           m_owner;
    bit           en_chk = 1'b0;

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(int src, int seq, bit eop, logic [31:0] dval);
        commit_rec_t r;
        r       = '0;
        r.wid   = 2'(src % 4);
        r.tmask = 4'hF;
        r.pc    = 32'h8000_0000 + 32'(src * 256 + seq * 4);
        r.rd    = 5'(seq);
        r.wb    = 1'b1;
        r.data  = {96'h0, dval};
        r.eop   = eop;
        return r;
    endfunction

    // Round-robin rule stated directly: the owner only while locked,
    // otherwise the first requester scanning from last+1 around the ring.
    function automatic int model_pick(logic [N-1:0] v);
        if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // ---------------- compare process + model ----------------
    always @(negedge clk) begin
        int           pick;
        bit           stall;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] d;
        pick    = model_pick(bus.req_valid);
        stall   = m_valid && !bus.out_ready;
        exp_rdy = (pick >= 0 && !stall) ? (N'(1) << pick) : '0;
        if (en_chk) begin
            check("req_ready", W'(bus.req_ready), W'(exp_rdy));
            check("out_valid", W'(bus.out_valid), W'(m_valid));
            check("out_sel",   W'(bus.out_sel),   W'(m_sel));
            check("out_data",  bus.out_data,      m_data);
            check("lock_state", W'(bus.dbg_lock_state == LOCK_LOCKED), W'(m_owner >= 0));
            if (bus.out_valid && bus.out_ready) begin
                ret_q.push_back(int'(bus.out_sel));
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL retire_order: got record %h, required none", bus.out_data);
                end else begin
                    check("retire_order", bus.out_data, exp_q.pop_front());
                end
            end
        end
        acc = bus.req_valid & bus.req_ready;
        if (reset) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 0;
            m_last  = N - 1;
            m_owner = -1;
            exp_q.delete();
            en_chk  = 1'b1;
        end else if (!stall) begin
            if (pick >= 0) begin
                d       = bus.req_data[pick];
                m_valid = 1'b1;
                m_data  = d;
                m_sel   = pick;
                m_last  = pick;
                exp_q.push_back(d);
                if (m_owner < 0 && !d[0]) m_owner = pick;
                else if (m_owner == pick && d[0]) m_owner = -1;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_srcs();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && (acc[i] || shown_gap[i])) void'(src_q[i].pop_front());
            acc[i]       = 1'b0;
            shown_gap[i] = 1'b0;
            if (src_q[i].size() > 0 && !src_q[i][0].gap) begin
                bus.req_valid[i] = 1'b1;
                bus.req_data[i]  = src_q[i][0].data;
            end else begin
                bus.req_valid[i] = 1'b0;
                shown_gap[i]     = (src_q[i].size() > 0);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        drive_srcs();
    endtask

    task automatic run(int n);
        repeat (n) cyc();
    endtask

    task automatic push(int i, logic [W-1:0] d);
        src_q[i].push_back('{gap: 1'b0, data: d});
    endtask

    task automatic push_gap(int i);
        src_q[i].push_back('{gap: 1'b1, data: '0});
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) src_q[i].delete();
        acc           = '0;
        shown_gap     = '0;
        bus.req_valid = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush();
        cyc();
        cyc();
        reset = 1'b0;
        ret_q.delete();
    endtask

    task automatic check_seq(string name, input int exp[$]);
        check({name, "_count"}, W'(ret_q.size()), W'(exp.size()));
        for (int i = 0; i < exp.size() && i < ret_q.size(); i++)
            check({name, "_sel"}, W'(ret_q[i]), W'(exp[i]));
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int e[$];
        logic [W-1:0] rec_a;
        logic [W-1:0] rec_b;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;

        // reset state
        do_reset();
        @(negedge clk);
        check("reset_out_valid", W'(bus.out_valid), '0);
        check("reset_out_data",  bus.out_data, '0);
        check("reset_out_sel",   W'(bus.out_sel), '0);

        // priority after reset: sources 0 and 3 together -> 0 then 3
        do_reset();
        push(COMMIT_SRC_ALU, mk(0, 0, 1'b1, 32'h0000_0A00));
        push(COMMIT_SRC_FPU, mk(3, 0, 1'b1, 32'h0000_0F00));
        run(5);
        e = '{0, 3};
        check_seq("priority", e);

        // round robin: all five valid, eop=1, two beats each
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push(i, mk(i, r, 1'b1, 32'(i * 16 + r)));
        run(13);
        e = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
        check_seq("round_robin", e);

        // lock: LSU packet with a 2-cycle hole, FPU waiting throughout
        do_reset();
        push(COMMIT_SRC_LSU, mk(1, 0, 1'b0, 32'h0000_1100));
        push_gap(COMMIT_SRC_LSU);
        push_gap(COMMIT_SRC_LSU);
        push(COMMIT_SRC_LSU, mk(1, 1, 1'b0, 32'h0000_1101));
        push(COMMIT_SRC_LSU, mk(1, 2, 1'b1, 32'h0000_1102));
        push(COMMIT_SRC_FPU, mk(3, 0, 1'b1, 32'h0000_3300));
        run(2);
        @(negedge clk);
        check("lock_hold_ready", W'(bus.req_ready), '0);
        check("lock_hold_owner", W'(bus.dbg_lock_owner), W'(COMMIT_SRC_LSU));
        run(8);
        e = '{1, 1, 1, 3};
        check_seq("lock", e);

        // backpressure: 4 stalled cycles, then retire + reload with no bubble
        do_reset();
        rec_a = mk(3, 0, 1'b1, 32'h3F80_0000);
        rec_b = mk(3, 1, 1'b1, 32'h4000_0000);
        bus.out_ready = 1'b0;
        push(COMMIT_SRC_FPU, rec_a);
        push(COMMIT_SRC_FPU, rec_b);
        cyc();
        cyc();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_hold_data",  bus.out_data, rec_a);
            check("bp_hold_ready", W'(bus.req_ready), '0);
            cyc();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_data", bus.out_data, rec_a);
        cyc();
        @(negedge clk);
        check("bp_reload_valid", W'(bus.out_valid), W'(1));
        check("bp_reload_data",  bus.out_data, rec_b);
        run(3);
        e = '{3, 3};
        check_seq("backpressure", e);

        // reset while LOCKED(1): partial packet dropped, then 2 beats 4
        do_reset();
        push(COMMIT_SRC_LSU, mk(1, 0, 1'b0, 32'h0000_5500));
        push(COMMIT_SRC_LSU, mk(1, 1, 1'b0, 32'h0000_5501));
        push(COMMIT_SRC_LSU, mk(1, 2, 1'b1, 32'h0000_5502));
        cyc();
        cyc();
        reset = 1'b1;
        flush();
        cyc();
        @(negedge clk);
        check("rst_lock_out_valid", W'(bus.out_valid), '0);
        check("rst_lock_state", W'(bus.dbg_lock_state == LOCK_LOCKED), '0);
        cyc();
        reset = 1'b0;
        ret_q.delete();
        push(COMMIT_SRC_CSR, mk(2, 0, 1'b1, 32'h0000_2200));
        push(COMMIT_SRC_GPU, mk(4, 0, 1'b1, 32'h0000_4400));
        run(5);
        e = '{2, 4};
        check_seq("rst_lock", e);

        // null traffic
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc();
            @(negedge clk);
            check("idle_out_valid", W'(bus.out_valid), '0);
            check("idle_req_ready", W'(bus.req_ready), '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
